io_dev_buffer: RTL and testbench

Parametrised DMA-facing peripheral buffer: a synchronous FIFO between a device-side stream port and the shared system bus. It raises a DMA request line when enough data or space is available, and moves one word per clock while the DMA controller holds acknowledge. It also exposes control, status and data registers to the CPU through the chip-selected `index` window.

---
 rtl/io_dev_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/io_dev_buffer.sv | 192 +++++++++++++++++++
 tb/tb_io_dev_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_dev_pkg.sv
// Shared definitions for the DMA-facing device buffer: register map,
// CTRL/STATUS bit positions and the DMA request state encoding.
package io_dev_pkg;

    // Register offsets relative to BASE_OFF inside the chip-selected window
    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_DATA   = 2;

    // CTRL bits
    localparam int CTRL_MODE_BIT = 0;
    localparam int CTRL_EN_BIT   = 1;
    localparam int CTRL_CLR_BIT  = 2;

    // STATUS bits
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 18;
    localparam int STAT_UDR_BIT   = 19;

    localparam logic MODE_RX = 1'b0;
    localparam logic MODE_TX = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } req_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; clr wins over both.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Next pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
            else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
        end
    end

    // Storage array, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wptr_q] <= wr_data;
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_dev_buffer.sv
// DMA-facing peripheral buffer: CPU register window, DMA ack data path,
// device stream ports and the DMA request FSM around one sync_fifo.
//
// state | meaning
// IDLE  | no request; waiting for enough data (RX) or space (TX)
// REQ   | gpio high, waiting for the DMA controller to acknowledge
// XFER  | one word per ack cycle until ack drops or FIFO empties/fills
module io_dev_buffer
    import io_dev_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int IDX_W     = 9,
    parameter int BASE_OFF  = 192,
    parameter int REQ_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  index,
    input  logic              io_write,
    input  logic              ack,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe,
    output logic              gpio,
    input  logic              dev_wr_valid,
    input  logic [DATA_W-1:0] dev_wr_data,
    output logic              dev_wr_ready,
    output logic              dev_rd_valid,
    output logic [DATA_W-1:0] dev_rd_data,
    input  logic              dev_rd_ready
);

    localparam int OFF_W = IDX_W - 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              mode_q, mode_d;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
    logic              udr_q, udr_d;
    logic [DATA_W-1:0] data_o_q, data_o_d;
    logic              data_oe_q;
    req_state_e        state_q;
    logic              gpio_q;

    logic [OFF_W-1:0]  off;
    logic              cpu_wr, cpu_rd;
    logic              sel_ctrl, sel_status, sel_data;
    logic              bus_push, bus_pop, clr;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count, fifo_free;
    logic [DATA_W-1:0] fifo_wr_data, fifo_rd_data;
    logic [DATA_W-1:0] ctrl_word, status_word;
    logic              req_cond, xfer_done;

    // CPU window is ignored whenever ack is high
    assign off        = index[IDX_W-2:0] - OFF_W'(BASE_OFF);
    assign cpu_wr     = index[IDX_W-1] & ~ack & io_write;
    assign cpu_rd     = index[IDX_W-1] & ~ack & ~io_write;
    assign sel_ctrl   = (off == OFF_W'(REG_CTRL));
    assign sel_status = (off == OFF_W'(REG_STATUS));
    assign sel_data   = (off == OFF_W'(REG_DATA));

    assign bus_push = (ack & io_write) | (cpu_wr & sel_data);
    assign bus_pop  = (ack & ~io_write) | (cpu_rd & sel_data);
    assign clr      = cpu_wr & sel_ctrl & data_i[CTRL_CLR_BIT];

    // Bus traffic owns the FIFO port in a cycle; the device side backs off
    assign dev_wr_ready = en_q & (mode_q == MODE_RX) & ~fifo_full & ~bus_push;
    assign dev_rd_valid = en_q & (mode_q == MODE_TX) & ~fifo_empty & ~bus_pop;
    assign dev_rd_data  = fifo_rd_data;

    assign fifo_push    = bus_push | (dev_wr_valid & dev_wr_ready);
    assign fifo_pop     = bus_pop | (dev_rd_valid & dev_rd_ready);
    assign fifo_wr_data = bus_push ? data_i : dev_wr_data;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clr     (clr),
        .wr_data (fifo_wr_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .rd_data (fifo_rd_data)
    );

    assign fifo_free = CNT_W'(DEPTH) - fifo_count;
    assign req_cond  = (mode_q == MODE_RX) ? (fifo_count >= CNT_W'(REQ_LEVEL))
                                           : (fifo_free >= CNT_W'(REQ_LEVEL));
    assign xfer_done = (mode_q == MODE_RX) ? fifo_empty : fifo_full;

    // Readback words for CTRL and STATUS
    always_comb begin
        ctrl_word                 = '0;
        ctrl_word[CTRL_MODE_BIT]  = mode_q;
        ctrl_word[CTRL_EN_BIT]    = en_q;
        status_word               = '0;
        status_word[STAT_COUNT_LSB +: CNT_W] = fifo_count;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_OVF_BIT]   = ovf_q;
        status_word[STAT_UDR_BIT]   = udr_q;
    end

    // Next values for control, sticky flags and read data
    always_comb begin
        mode_d   = mode_q;
        en_d     = en_q;
        ovf_d    = ovf_q;
        udr_d    = udr_q;
        data_o_d = data_o_q;
        if (cpu_wr && sel_ctrl) begin
            mode_d = data_i[CTRL_MODE_BIT];
            en_d   = data_i[CTRL_EN_BIT];
        end
        if (clr) begin
            ovf_d = 1'b0;
            udr_d = 1'b0;
        end else begin
            if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
            if (fifo_pop && fifo_empty)              udr_d = 1'b1;
        end
        // An empty pop leaves the previous word on the bus
        if (bus_pop) begin
            if (!fifo_empty) data_o_d = fifo_rd_data;
        end else if (cpu_rd) begin
            if (sel_ctrl)        data_o_d = ctrl_word;
            else if (sel_status) data_o_d = status_word;
            else                 data_o_d = '0;
        end
    end

    // Control, flag and bus-read registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_RX;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            udr_q     <= 1'b0;
            data_o_q  <= '0;
            data_oe_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            udr_q     <= udr_d;
            data_o_q  <= data_o_d;
            data_oe_q <= (ack & ~io_write) | cpu_rd;
        end
    end

    // DMA request FSM with registered gpio
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gpio_q  <= 1'b0;
        end else if (!en_q) begin
            state_q <= IDLE;
            gpio_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_cond) begin
                    state_q <= REQ;
                    gpio_q  <= 1'b1;
                end
                REQ: if (ack) begin
                    state_q <= XFER;
                    gpio_q  <= 1'b1;
                end
                XFER: if (!ack || xfer_done) begin
                    state_q <= IDLE;
                    gpio_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gpio_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o  = data_o_q;
    assign data_oe = data_oe_q;
    assign gpio    = gpio_q;

endmodule

// File: tb/tb_io_dev_buffer.sv
// Bench for io_dev_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_io_dev_buffer;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 32;
    localparam int IDX_W     = 9;
    localparam int BASE_OFF  = 192;
    localparam int REQ_LEVEL = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [IDX_W-1:0]  index = '0;
    logic              io_write = 1'b0;
    logic              ack = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic [DATA_W-1:0] data_o;
    logic              data_oe;
    logic              gpio;
    logic              dev_wr_valid = 1'b0;
    logic [DATA_W-1:0] dev_wr_data = '0;
    logic              dev_wr_ready;
    logic              dev_rd_valid;
    logic [DATA_W-1:0] dev_rd_data;
    logic              dev_rd_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    io_dev_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
        .BASE_OFF(BASE_OFF), .REQ_LEVEL(REQ_LEVEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .index(index), .io_write(io_write),
        .ack(ack), .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
        .gpio(gpio), .dev_wr_valid(dev_wr_valid), .dev_wr_data(dev_wr_data),
        .dev_wr_ready(dev_wr_ready), .dev_rd_valid(dev_rd_valid),
        .dev_rd_data(dev_rd_data), .dev_rd_ready(dev_rd_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q[$];
    bit          m_mode, m_en, m_ovf, m_udr, m_oe;
    logic [31:0] m_data_o;
    int          m_phase;   // 0 no request, 1 requested, 2 transferring

    function automatic logic [7:0] f_off();
        return index[7:0] - 8'(BASE_OFF);
    endfunction
    function automatic bit f_cwr();
        return index[8] && !ack && io_write;
    endfunction
    function automatic bit f_crd();
        return index[8] && !ack && !io_write;
    endfunction
    function automatic bit f_bpush();
        return (ack && io_write) || (f_cwr() && f_off() == 8'd2);
    endfunction
    function automatic bit f_bpop();
        return (ack && !io_write) || (f_crd() && f_off() == 8'd2);
    endfunction
    function automatic bit f_wr_ready();
        return m_en && !m_mode && q.size() < DEPTH && !f_bpush();
    endfunction
    function automatic bit f_rd_valid();
        return m_en && m_mode && q.size() > 0 && !f_bpop();
    endfunction

    task automatic model_step();
        int          cnt;
        bit          mfull, mempty, bpush, bpop, dpush, dpop, push, pop, clr, cond, done;
        logic [7:0]  off;
        logic [31:0] w, ctrl_w, stat_w;
        cnt    = q.size();
        mfull  = (cnt == DEPTH);
        mempty = (cnt == 0);
        off    = f_off();
        bpush  = f_bpush();
        bpop   = f_bpop();
        dpush  = dev_wr_valid && f_wr_ready();
        dpop   = dev_rd_ready && f_rd_valid();
        ctrl_w = {30'd0, m_en, m_mode};
        stat_w = {12'd0, m_udr, m_ovf, mfull, mempty, 16'(cnt)};
        cond   = m_mode ? ((DEPTH - cnt) >= REQ_LEVEL) : (cnt >= REQ_LEVEL);
        done   = m_mode ? mfull : mempty;
        if (!m_en) m_phase = 0;
        else if (m_phase == 0 && cond) m_phase = 1;
        else if (m_phase == 1 && ack) m_phase = 2;
        else if (m_phase == 2 && (!ack || done)) m_phase = 0;
        if (bpop) begin
            if (!mempty) m_data_o = q[0];
        end else if (f_crd()) begin
            m_data_o = (off == 8'd0) ? ctrl_w : (off == 8'd1) ? stat_w : 32'd0;
        end
        m_oe = (ack && !io_write) || f_crd();
        clr  = f_cwr() && off == 8'd0 && data_i[2];
        if (clr) begin
            q.delete();
            m_ovf = 0;
            m_udr = 0;
        end else begin
            push = bpush || dpush;
            pop  = bpop || dpop;
            w    = bpush ? data_i : dev_wr_data;
            if (pop) begin
                if (!mempty) void'(q.pop_front());
                else m_udr = 1;
            end
            if (push) begin
                if (mfull && !pop) m_ovf = 1;
                else q.push_back(w);
            end
        end
        if (f_cwr() && off == 8'd0) begin
            m_mode = data_i[0];
            m_en   = data_i[1];
        end
    endtask

    // Model advances on the same edges the DUT samples
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_mode = 0; m_en = 0; m_ovf = 0; m_udr = 0; m_oe = 0;
            m_data_o = '0; m_phase = 0;
        end else begin
            model_step();
        end
    end

    // Compare process: DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("data_oe", 32'(data_oe), 32'(m_oe));
            chk("data_o", data_o, m_data_o);
            chk("gpio", 32'(gpio), 32'(m_phase != 0));
            chk("dev_wr_ready", 32'(dev_wr_ready), 32'(f_wr_ready()));
            chk("dev_rd_valid", 32'(dev_rd_valid), 32'(f_rd_valid()));
            if (f_rd_valid()) chk("dev_rd_data", dev_rd_data, q[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus();
        index = '0; io_write = 1'b0; ack = 1'b0; data_i = '0;
    endtask

    task automatic cpu_write(input int off, input logic [31:0] d);
        index = {1'b1, 8'(BASE_OFF + off)}; io_write = 1'b1; ack = 1'b0; data_i = d;
        tick();
        idle_bus();
    endtask

    task automatic cpu_read(input int off, output logic [31:0] v);
        index = {1'b1, 8'(BASE_OFF + off)}; io_write = 1'b0; ack = 1'b0;
        tick();
        v = data_o;
        idle_bus();
    endtask

    task automatic rx_burst(input logic [31:0] base);
        logic [31:0] v;
        cpu_write(0, 32'h6);
        for (int i = 0; i < 4; i++) begin
            dev_wr_valid = 1'b1; dev_wr_data = base + 32'(i);
            tick();
        end
        dev_wr_valid = 1'b0;
        chk("rx_gpio_pre", 32'(gpio), 32'd0);
        tick();
        chk("rx_gpio_up", 32'(gpio), 32'd1);
        ack = 1'b1; io_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rx_data", data_o, base + 32'(i));
            chk("rx_oe", 32'(data_oe), 32'd1);
        end
        ack = 1'b0;
        tick();
        chk("rx_gpio_down", 32'(gpio), 32'd0);
        cpu_read(1, v);
        chk("rx_status", v, 32'h0001_0000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v;
        #3;
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_gpio", 32'(gpio), 32'd0);
        chk("rst_wr_ready", 32'(dev_wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(dev_rd_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // RX burst
        rx_burst(32'd5);

        // Overflow then underrun, then clear
        cpu_write(0, 32'h6);
        ack = 1'b1; io_write = 1'b1;
        for (int i = 0; i < 33; i++) begin
            data_i = 32'h200 + 32'(i);
            tick();
        end
        idle_bus();
        cpu_read(1, v);
        chk("ovf_status", v, 32'h0006_0020);
        ack = 1'b1; io_write = 1'b0;
        for (int i = 0; i < 33; i++) begin
            tick();
            if (i == 0)  chk("udr_first", data_o, 32'h200);
            if (i == 31) chk("udr_last", data_o, 32'h21F);
            if (i == 32) chk("udr_repeat", data_o, 32'h21F);
        end
        idle_bus();
        cpu_read(1, v);
        chk("udr_status", v, 32'h000D_0000);
        cpu_write(0, 32'h6);
        cpu_read(1, v);
        chk("clr_status", v, 32'h0001_0000);

        // CPU path in TX mode and ack priority over CS
        cpu_write(0, 32'h7);
        cpu_write(2, 32'hDEADBEEF);
        cpu_read(1, v);
        chk("cpu_count1", v, 32'h0000_0001);
        index = {1'b1, 8'(BASE_OFF + 2)}; io_write = 1'b1; ack = 1'b1; data_i = 32'hCAFE0001;
        tick();
        idle_bus();
        cpu_read(1, v);
        chk("cpu_count2", v, 32'h0000_0002);
        chk("cpu_head", dev_rd_data, 32'hDEADBEEF);
        dev_rd_ready = 1'b1;
        tick();
        dev_rd_ready = 1'b0;
        chk("cpu_second", dev_rd_data, 32'hCAFE0001);

        // TX burst
        cpu_write(0, 32'h7);
        tick();
        chk("tx_gpio_up", 32'(gpio), 32'd1);
        ack = 1'b1; io_write = 1'b1;
        for (int i = 0; i < 32; i++) begin
            data_i = 32'h100 + 32'(i);
            tick();
        end
        idle_bus();
        tick();
        chk("tx_gpio_down", 32'(gpio), 32'd0);
        cpu_read(1, v);
        chk("tx_status", v, 32'h0002_0020);
        chk("tx_rd_valid", 32'(dev_rd_valid), 32'd1);
        chk("tx_head", dev_rd_data, 32'h100);
        dev_rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        dev_rd_ready = 1'b0;
        cpu_read(1, v);
        chk("tx_drained", v, 32'h0001_0000);

        // Reset in the middle of an RX transfer
        cpu_write(0, 32'h6);
        for (int i = 0; i < 4; i++) begin
            dev_wr_valid = 1'b1; dev_wr_data = 32'h20 + 32'(i);
            tick();
        end
        dev_wr_valid = 1'b0;
        tick();
        ack = 1'b1; io_write = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_gpio", 32'(gpio), 32'd0);
        chk("midrst_oe", 32'(data_oe), 32'd0);
        chk("midrst_data_o", data_o, 32'd0);
        idle_bus();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        cpu_read(1, v);
        chk("midrst_status", v, 32'h0001_0000);
        rx_burst(32'h31);

        // Pointer wrap at steady occupancy of three
        cpu_write(0, 32'h6);
        for (int i = 0; i < 3; i++) begin
            dev_wr_valid = 1'b1; dev_wr_data = 32'h40 + 32'(i);
            tick();
        end
        for (int i = 0; i < 100; i++) begin
            dev_wr_valid = 1'b1; dev_wr_data = 32'h43 + 32'(i);
            ack = 1'b1; io_write = 1'b0;
            tick();
        end
        dev_wr_valid = 1'b0;
        idle_bus();
        chk("wrap_last", data_o, 32'hA3);
        cpu_read(1, v);
        chk("wrap_status", v, 32'h0000_0003);

        // Randomized traffic
        cpu_write(0, 32'h2);
        for (int i = 0; i < 3000; i++) begin
            int r;
            int off;
            idle_bus();
            r = int'($urandom_range(0, 99));
            data_i = $urandom;
            if (r < 30) begin
                ack = 1'b1;
                io_write = ($urandom_range(0, 9) < 8) ? m_mode : ~m_mode;
                if ($urandom_range(0, 3) == 0) index = {1'b1, 8'(BASE_OFF + int'($urandom_range(0, 2)))};
                else index = {1'b0, 8'($urandom)};
            end else if (r < 55) begin
                int p;
                p = int'($urandom_range(0, 9));
                off = (p < 1) ? 0 : (p < 4) ? 1 : (p < 8) ? 2 : int'($urandom_range(3, 255));
                io_write = 1'($urandom_range(0, 1));
                index = {1'b1, 8'(BASE_OFF + off)};
                if (off == 0 && io_write)
                    data_i = {29'd0, 1'($urandom_range(0, 7) == 0),
                              1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1))};
            end else begin
                index = {1'b0, 8'($urandom)};
                io_write = 1'($urandom_range(0, 1));
            end
            dev_wr_valid = 1'($urandom_range(0, 1));
            dev_wr_data  = $urandom;
            dev_rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        idle_bus();
        dev_wr_valid = 1'b0;
        dev_rd_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
